// File: rtl/pixel_phrase_builder.sv
// Packs 16-bit RGB565 pixels into frame-aligned 128-bit phrases behind a 2-entry AXI-Stream buffer.
// Build option: define PHRASE_BUILDER_TEST_PATTERN_EN to replace pixel data with the in-frame pixel index.
module pixel_phrase_builder #(
  parameter int H_PIXELS      = 1280,
  parameter int V_PIXELS      = 720,
  parameter int FRAME_PHRASES = H_PIXELS * V_PIXELS / 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [15:0]  pixel_data_in,
  input  logic         pixel_valid_in,
  input  logic         frame_start_in,
  output logic [127:0] phrase_axis_data,
  output logic         phrase_axis_valid,
  output logic         phrase_axis_last,
  input  logic         phrase_axis_ready,
  output logic         overflow_out,
  output logic         frame_error_out,
  output logic [1:0]   state_out
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    PACK       = 2'd1
  } state_t;

  localparam logic [16:0] LAST_PHRASE = 17'(FRAME_PHRASES - 1);

  state_t       state_q, state_d;
  logic [2:0]   pixIdx_q, pixIdx_d;
  logic [16:0]  phraseIdx_q, phraseIdx_d;
  logic [127:0] shift_q, shift_d;
  logic [128:0] fifoMem_q [2];
  logic [128:0] fifoMem_d [2];
  logic         rdPtr_q, rdPtr_d;
  logic         wrPtr_q, wrPtr_d;
  logic [1:0]   count_q, count_d;
  logic         overflow_q, overflow_d;
  logic         frameErr_q, frameErr_d;

  logic         startHit;
  logic         phraseDone;
  logic         phraseLast;
  logic [127:0] phraseData;
  logic         pop;
  logic         pushOk;
  logic [15:0]  pixVal;

  assign startHit = pixel_valid_in && frame_start_in;

`ifdef PHRASE_BUILDER_TEST_PATTERN_EN
  // A frame-start pixel is always index 0, regardless of where the counters were.
  assign pixVal = startHit ? 16'd0 : {phraseIdx_q[12:0], pixIdx_q};
`else
  assign pixVal = pixel_data_in;
`endif

  always_comb begin
    state_d     = state_q;
    pixIdx_d    = pixIdx_q;
    phraseIdx_d = phraseIdx_q;
    shift_d     = shift_q;
    frameErr_d  = frameErr_q;
    overflow_d  = overflow_q;
    fifoMem_d   = fifoMem_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    phraseDone  = 1'b0;
    phraseLast  = 1'b0;
    phraseData  = '0;

    unique case (state_q)
      WAIT_FRAME: begin
        if (startHit) begin
          shift_d     = {112'd0, pixVal};
          pixIdx_d    = 3'd1;
          phraseIdx_d = '0;
          state_d     = PACK;
        end
      end
      PACK: begin
        if (startHit) begin
          if (pixIdx_q != 3'd0 || phraseIdx_q != 17'd0) frameErr_d = 1'b1;
          shift_d     = {112'd0, pixVal};
          pixIdx_d    = 3'd1;
          phraseIdx_d = '0;
        end else if (pixel_valid_in) begin
          shift_d[{pixIdx_q, 4'd0} +: 16] = pixVal;
          pixIdx_d = pixIdx_q + 3'd1;
          if (pixIdx_q == 3'd7) begin
            phraseDone = 1'b1;
            phraseData = {pixVal, shift_q[111:0]};
            phraseLast = (phraseIdx_q == LAST_PHRASE);
            if (phraseLast) begin
              phraseIdx_d = '0;
              state_d     = WAIT_FRAME;
            end else begin
              phraseIdx_d = phraseIdx_q + 17'd1;
            end
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    // A pop frees the head slot in the same cycle, so a full buffer can still take a push.
    pop    = (count_q != 2'd0) && phrase_axis_ready;
    pushOk = phraseDone && ((count_q != 2'd2) || pop);
    if (phraseDone && !pushOk) overflow_d = 1'b1;

    if (pushOk) begin
      fifoMem_d[wrPtr_q] = {phraseLast, phraseData};
      wrPtr_d = ~wrPtr_q;
    end
    if (pop) rdPtr_d = ~rdPtr_q;

    unique case ({pushOk, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= WAIT_FRAME;
      pixIdx_q     <= '0;
      phraseIdx_q  <= '0;
      shift_q      <= '0;
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      rdPtr_q      <= 1'b0;
      wrPtr_q      <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixIdx_q     <= pixIdx_d;
      phraseIdx_q  <= phraseIdx_d;
      shift_q      <= shift_d;
      fifoMem_q[0] <= fifoMem_d[0];
      fifoMem_q[1] <= fifoMem_d[1];
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frameErr_q   <= frameErr_d;
    end
  end

  assign phrase_axis_valid = (count_q != 2'd0);
  assign phrase_axis_data  = phrase_axis_valid ? fifoMem_q[rdPtr_q][127:0] : '0;
  assign phrase_axis_last  = phrase_axis_valid && fifoMem_q[rdPtr_q][128];
  assign overflow_out      = overflow_q;
  assign frame_error_out   = frameErr_q;
  assign state_out         = state_q;

endmodule

// File: tb/tb_pixel_phrase_builder.sv
// Scoreboard bench for pixel_phrase_builder on a reduced 64x4 frame (32 phrases per frame).
module tb_pixel_phrase_builder;

  localparam int H = 64;
  localparam int V = 4;
  localparam int FP = H * V / 8;
  localparam int FRAME_PIX = H * V;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [15:0]  pixel_data_in;
  logic         pixel_valid_in;
  logic         frame_start_in;
  logic [127:0] phrase_axis_data;
  logic         phrase_axis_valid;
  logic         phrase_axis_last;
  logic         phrase_axis_ready;
  logic         overflow_out;
  logic         frame_error_out;
  logic [1:0]   state_out;

  always #5 clk = ~clk;

  pixel_phrase_builder #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .pixel_data_in     (pixel_data_in),
    .pixel_valid_in    (pixel_valid_in),
    .frame_start_in    (frame_start_in),
    .phrase_axis_data  (phrase_axis_data),
    .phrase_axis_valid (phrase_axis_valid),
    .phrase_axis_last  (phrase_axis_last),
    .phrase_axis_ready (phrase_axis_ready),
    .overflow_out      (overflow_out),
    .frame_error_out   (frame_error_out),
    .state_out         (state_out)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         expQ[$];
  int           checks = 0;
  int           failures = 0;
  bit           inFrame = 0;
  int           pos = 0;
  logic [127:0] asmPhrase = '0;
  int           dropPhrase = -1;
  bit           expErr = 0;
  bit           readyMode = 0;
  int           cyc = 0;
  int           delivered = 0;
  int           lastSeen = 0;
  bit           captureFirst = 0;
  logic [127:0] firstData = '0;
  bit           holdValid = 0;
  logic [127:0] holdData = '0;
  logic         holdLast = 1'b0;

  localparam logic [127:0] PHRASE0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle and advances the reference packer, which sees pixels in frame order.
  task automatic applyStimulus(input logic [15:0] data, input logic valid, input logic start);
    exp_t e;
    int   num;
    pixel_data_in  = data;
    pixel_valid_in = valid;
    frame_start_in = start;
    if (readyMode) phrase_axis_ready = (cyc % 4 == 0);
    cyc++;
    if (valid) begin
      if (start) begin
        if (inFrame && pos != 0) expErr = 1;
        inFrame = 1;
        pos = 0;
      end
      if (inFrame) begin
        asmPhrase[(pos % 8) * 16 +: 16] = data;
        pos++;
        if (pos % 8 == 0) begin
          num = pos / 8 - 1;
          e.data = asmPhrase;
          e.last = (num == FP - 1);
          if (num != dropPhrase) expQ.push_back(e);
          if (num == FP - 1) inFrame = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendPixels(input int base, input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) applyStimulus(16'hDEAD, 1'b0, 1'b1);
      applyStimulus(16'(base + i), 1'b1, i == 0);
    end
  endtask

  task automatic applyReset(input int n);
    rst_in = 1'b0;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_in = 1'b1;
    expQ.delete();
    inFrame = 0;
    pos = 0;
    expErr = 0;
    dropPhrase = -1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("drain", 128'(expQ.size()), 128'd0);
  endtask

  // Pops the scoreboard on each handshake and checks that a stalled head holds steady.
  always @(negedge clk) begin
    exp_t e;
    if (rst_in) begin
      if (phrase_axis_valid && phrase_axis_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPhrase", phrase_axis_data, 128'hx);
        end else begin
          e = expQ.pop_front();
          checkOutput("phraseData", phrase_axis_data, e.data);
          checkOutput("phraseLast", 128'(phrase_axis_last), 128'(e.last));
        end
        delivered++;
        if (phrase_axis_last) lastSeen++;
        if (captureFirst) begin
          firstData = phrase_axis_data;
          captureFirst = 0;
        end
      end
      if (holdValid) begin
        checkOutput("holdValid", 128'(phrase_axis_valid), 128'd1);
        checkOutput("holdData", phrase_axis_data, holdData);
        checkOutput("holdLast", 128'(phrase_axis_last), 128'(holdLast));
      end
      holdValid = phrase_axis_valid && !phrase_axis_ready;
      holdData  = phrase_axis_data;
      holdLast  = phrase_axis_last;
    end else begin
      holdValid = 0;
    end
  end

  initial begin
    int d0;
    int l0;
    rst_in = 1'b0;
    pixel_data_in = '0;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    phrase_axis_ready = 1'b0;
    @(posedge clk);
    #1;
    applyReset(3);

    checkOutput("resetValid", 128'(phrase_axis_valid), 128'd0);
    checkOutput("resetData", phrase_axis_data, 128'd0);
    checkOutput("resetLast", 128'(phrase_axis_last), 128'd0);
    checkOutput("resetOverflow", 128'(overflow_out), 128'd0);
    checkOutput("resetFrameErr", 128'(frame_error_out), 128'd0);
    checkOutput("resetState", 128'(state_out), 128'd0);

    // Pre-frame pixels are discarded, then one full frame with idle gaps.
    phrase_axis_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(16'(16'hA000 + i), 1'b1, 1'b0);
    applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("preFrameValid", 128'(phrase_axis_valid), 128'd0);
    checkOutput("preFrameState", 128'(state_out), 128'd0);
    captureFirst = 1;
    d0 = delivered;
    l0 = lastSeen;
    sendPixels(0, 0, 1, 0);
    checkOutput("packState", 128'(state_out), 128'd1);
    sendPixels(0, 1, FRAME_PIX - 1, 1);
    checkOutput("endState", 128'(state_out), 128'd0);
    waitDrain();
    checkOutput("firstPhrase", firstData, PHRASE0);
    checkOutput("phraseCount", 128'(delivered - d0), 128'(FP));
    checkOutput("lastCount", 128'(lastSeen - l0), 128'd1);
    checkOutput("noFrameErr", 128'(frame_error_out), 128'd0);
    checkOutput("noOverflow", 128'(overflow_out), 128'd0);

    // Backpressure across three phrases: third one is lost, counters keep going.
    phrase_axis_ready = 1'b0;
    dropPhrase = 2;
    sendPixels(0, 0, 24, 0);
    applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("overflowSet", 128'(overflow_out), 128'd1);
    checkOutput("stalledValid", 128'(phrase_axis_valid), 128'd1);
    checkOutput("stalledHead", phrase_axis_data, PHRASE0);
    phrase_axis_ready = 1'b1;
    sendPixels(0, 24, FRAME_PIX - 24, 0);
    waitDrain();
    checkOutput("overflowSticky", 128'(overflow_out), 128'd1);
    applyReset(2);
    checkOutput("overflowCleared", 128'(overflow_out), 128'd0);

    // Early frame_start at pixel 13 abandons the partial phrase.
    phrase_axis_ready = 1'b1;
    sendPixels(0, 0, 13, 0);
    checkOutput("preRestartErr", 128'(frame_error_out), 128'd0);
    sendPixels(16'h4000, 0, FRAME_PIX, 0);
    checkOutput("frameErrSet", 128'(frame_error_out), 128'(expErr));
    checkOutput("frameErrFixed", 128'(frame_error_out), 128'd1);
    waitDrain();

    // Reset with two phrases buffered and five pixels packed.
    applyReset(1);
    phrase_axis_ready = 1'b0;
    sendPixels(16'h6000, 0, 21, 0);
    checkOutput("bufferedValid", 128'(phrase_axis_valid), 128'd1);
    applyReset(1);
    checkOutput("flushValid", 128'(phrase_axis_valid), 128'd0);
    checkOutput("flushData", phrase_axis_data, 128'd0);
    checkOutput("flushFrameErr", 128'(frame_error_out), 128'd0);
    checkOutput("flushOverflow", 128'(overflow_out), 128'd0);
    checkOutput("flushState", 128'(state_out), 128'd0);
    phrase_axis_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(16'(16'h6100 + i), 1'b1, 1'b0);
    checkOutput("noStaleValid", 128'(phrase_axis_valid), 128'd0);
    sendPixels(16'h7000, 0, FRAME_PIX, 0);
    waitDrain();

    // Sparse ready: heads wait several cycles and must stay stable.
    readyMode = 1;
    sendPixels(16'h9000, 0, FRAME_PIX, 0);
    waitDrain();
    readyMode = 0;
    checkOutput("sparseOverflow", 128'(overflow_out), 128'd0);
    checkOutput("sparseState", 128'(state_out), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
